// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Sized for the widest legal format; callers cast down to W bits.
    function automatic logic [34:0] canon_qnan(input int unsigned exp_w,
                                               input int unsigned man_w);
        logic [34:0] q;
        q = ((35'd1 << exp_w) - 35'd1) << man_w;
        q = q | (35'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalise, round-to-nearest-even, pack and raise flags for one product.
module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [2*MAN_W+1:0]     prod,
    input  logic signed [EXP_W+1:0] exp_sum,
    input  fp_class_t              cls,
    input  logic                   sign,
    input  logic                   invalid,
    output logic [W-1:0]           result,
    output logic [3:0]             flags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] E_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

    logic                    msb;
    logic                    guard;
    logic                    sticky;
    logic                    rnd;
    logic                    carry;
    logic [PW-1:0]           norm;
    logic [MAN_W:0]          kept;
    logic [MAN_W+1:0]        sum;
    logic [MAN_W-1:0]        frac;
    logic signed [EXP_W+1:0] e_fin;

    // Left-align so the hidden bit always sits at the top.
    assign msb    = prod[PW-1];
    assign norm   = msb ? prod : prod << 1;
    assign kept   = norm[PW-1 -: MAN_W+1];
    assign guard  = norm[MAN_W];
    assign sticky = |norm[MAN_W-1:0];
    assign rnd    = guard & (sticky | kept[0]);
    assign sum    = {1'b0, kept} + {{(MAN_W+1){1'b0}}, rnd};
    assign carry  = sum[MAN_W+1];
    assign frac   = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    assign e_fin  = exp_sum
                  + {{(EXP_W+1){1'b0}}, msb}
                  + {{(EXP_W+1){1'b0}}, carry};

    always_comb begin
        result = '0;
        flags  = '0;
        unique case (cls)
            NAN: begin
                result              = QNAN;
                flags[FLAG_INVALID] = invalid;
            end
            INF:  result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ZERO: result = {sign, {(W-1){1'b0}}};
            NORM: begin
                flags[FLAG_INEXACT] = guard | sticky;
                if (e_fin >= EMAX) begin
                    result               = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags[FLAG_OVERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]  = 1'b1;
                end else if (e_fin < E_ONE) begin
                    result                = {sign, {(W-1){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    result = {sign, e_fin[EXP_W-1:0], frac};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with valid/ready on both sides.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam int unsigned BIAS = bias(EXP_W);
    localparam logic [XW-1:0] BIAS_X = XW'(BIAS);

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0) return ZERO;
        if (&e) return (f == '0) ? INF : NAN;
        return NORM;
    endfunction

    fp_class_t      ca, cb, c0;
    logic           inv0;
    logic [XW-1:0]  e0;
    logic           v1, v2, v3;
    logic           load1, load2, load3;

    logic           s1_sign, s1_inv;
    fp_class_t      s1_cls;
    logic [XW-1:0]  s1_exp;
    logic [SW-1:0]  s1_sa, s1_sb;

    logic           s2_sign, s2_inv;
    fp_class_t      s2_cls;
    logic [XW-1:0]  s2_exp;
    logic [PW-1:0]  s2_prod;

    logic [W-1:0]   r_res;
    logic [3:0]     r_flags;

    assign ca = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
    assign cb = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
    assign e0 = {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]} - BIAS_X;

    // Earlier arms win: NaN beats inf*0, which beats inf, which beats zero.
    always_comb begin
        c0   = NORM;
        inv0 = 1'b0;
        priority case (1'b1)
            (ca == NAN || cb == NAN): c0 = NAN;
            ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)): begin
                c0   = NAN;
                inv0 = 1'b1;
            end
            (ca == INF || cb == INF):   c0 = INF;
            (ca == ZERO || cb == ZERO): c0 = ZERO;
            default: ;
        endcase
    end

    assign load3     = !v3 || out_ready;
    assign load2     = !v2 || load3;
    assign load1     = !v1 || load2;
    assign in_ready  = load1;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_inv  <= 1'b0;
            s1_cls  <= ZERO;
            s1_exp  <= '0;
            s1_sa   <= '0;
            s1_sb   <= '0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= a[W-1] ^ b[W-1];
                s1_inv  <= inv0;
                s1_cls  <= c0;
                s1_exp  <= e0;
                s1_sa   <= {1'b1, a[MAN_W-1:0]};
                s1_sb   <= {1'b1, b[MAN_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_inv  <= 1'b0;
            s2_cls  <= ZERO;
            s2_exp  <= '0;
            s2_prod <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_sign;
                s2_inv  <= s1_inv;
                s2_cls  <= s1_cls;
                s2_exp  <= s1_exp;
                s2_prod <= PW'(s1_sa) * PW'(s1_sb);
            end
        end
    end

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod    (s2_prod),
        .exp_sum (s2_exp),
        .cls     (s2_cls),
        .sign    (s2_sign),
        .invalid (s2_inv),
        .result  (r_res),
        .flags   (r_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3     <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                result <= r_res;
                flags  <= r_flags;
            end
        end
    end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-style floating-point multiplier for the signed multiplier family; BFloat16 is the default format. It fixes the behaviour the earlier combinational multiplier lacked: bias arithmetic, hidden bit, round-to-nearest-even, special operands and exception flags. It adds a three-stage pipeline with valid/ready handshakes on both sides and sits between operand-producing logic and any result consumer.

## Interface
- `EXP_W`, default 8: exponent field width, 3 to 11.
- `MAN_W`, default 7: stored fraction width, 2 to 23.
- `W`, derived, 1+EXP_W+MAN_W: operand and result width. Not overridable.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair `a`/`b` is valid.
- `in_ready` out 1: block accepts the pair this cycle.
- `a`, `b` in W each: operands, laid out {sign, exponent, fraction}.
- `out_valid` out 1: `result` and `flags` are valid.
- `out_ready` in 1: consumer takes the result this cycle.
- `result` out W: product.
- `flags` out 4: {invalid, overflow, underflow, inexact}.

## Operation
- `BIAS` = 2^(EXP_W-1)-1. `EMAX` = 2^EXP_W-1 (all-ones exponent).
- Operand classes:
  - ZERO: exponent 0. Subnormals are treated as zero (DAZ) and raise no flag.
  - INF: exponent EMAX, fraction 0.
  - NAN: exponent EMAX, fraction not 0.
  - NORM: all other encodings.
- Sign is sign_a XOR sign_b, except on NaN results.
- Special-case priority:
  1. Any NAN operand: result is the canonical qNaN {0, EMAX, 1 followed by MAN_W-1 zeros}, no flags.
  2. INF with ZERO: canonical qNaN, invalid=1.
  3. INF with INF or NORM: signed infinity, no flags.
  4. ZERO with ZERO or NORM: signed zero, no flags.
- NORM × NORM:
  - Significands {1,frac} are MAN_W+1 bits; the product is 2·MAN_W+2 bits.
  - Exponent is held signed in EXP_W+2 bits: e = ea + eb − BIAS.
  - If product MSB = 1, take the upper MAN_W+1 bits and set e += 1.
  - guard = next bit below the kept bits; sticky = OR of all remaining bits.
  - RNE: increment when guard & (sticky | lsb). A mantissa carry-out renormalises and sets e += 1.
  - inexact = guard | sticky.
  - If e ≥ EMAX: signed infinity, overflow=1, inexact=1.
  - If e ≤ 0: signed zero (FTZ), underflow=1, inexact=1.
- Results leave in acceptance order. No reordering, loss or duplication.

## Timing
- Pipeline stages:
  - S1: unpack, classify, exponent sum.
  - S2: significand multiply.
  - S3: normalise, round, pack, flags.
- Latency: 3 cycles from the `in_valid & in_ready` edge to `out_valid`, given no backpressure. Throughput is 1 result per cycle.
- Per-stage valid bits. A stage loads when it is empty or its contents move on this cycle:
  - `in_ready` = !v1 | (v1 & load2); the same rule holds at each stage.
  - S3 drains when `out_ready` = 1.
- Maximum 3 results in flight. With `out_ready` held 0, `in_ready` falls after the third accept.
- While `out_valid` = 1 and `out_ready` = 0, `result` and `flags` hold stable.
- `in_valid` may drop at any time; bubbles propagate as invalid stages.
- Reset, asynchronous and allowed mid-operation:
  - All stage valids clear and in-flight operations are discarded.
  - Outputs go to `out_valid`=0, `result`=0, `flags`=0.
  - `in_ready`=1 from the first edge after release.
- Handshake inputs are ignored while `rst_n`=0.

## Structure
- Package `fp_mul_pkg` holds:
  - class enum {ZERO, NORM, INF, NAN};
  - flag bit index constants;
  - functions `bias(EXP_W)` and `canon_qnan(EXP_W, MAN_W)`.
- Sub-module `fp_mul_round` (combinational, used in S3) takes the product, exponent and class and returns packed result plus flags.
- Expected size: ~250 RTL lines in total.

## Test plan
All values are BFloat16 defaults.
- Simple products, streaming with `out_ready`=1:
  - 0x3FC0 × 0x4000 → 0x4040, flags 0.
  - 0xBFC0 × 0x3FC0 → 0xC010, flags 0.
  - Back-to-back inputs give back-to-back outputs 3 cycles later.
- Rounding:
  - 0x3F81 × 0x3F81 → 0x3F82, inexact=1 (round down).
  - 0x3F81 × 0x3FC0 → 0x3FC2, inexact=1 (tie, odd lsb, round up).
- Exceptions:
  - 0x7F00 × 0x4000 → 0x7F80, overflow=1, inexact=1.
  - 0x0080 × 0x3F00 → 0x0000, underflow=1, inexact=1.
- Specials:
  - 0x7F80 × 0x0000 → 0x7FC0, invalid=1.
  - 0x7FC1 × 0x3F80 → 0x7FC0, flags 0.
  - 0xFF80 × 0x4000 → 0xFF80.
  - 0x0001 × 0x4000 → 0x0000, no flags.
- Backpressure:
  - Stream 6 ops with `out_ready`=0. Exactly 3 are accepted, `in_ready` falls, and `result` stays stable.
  - Release `out_ready`: all 6 results appear in order, no gaps.
- Reset mid-stream: assert `rst_n`=0 with 2 ops in flight → `out_valid`=0 immediately, and no stale result appears after release.
